// File: rtl/detect_sequence_programmable.sv
// Serial bit-pattern detector with a runtime-programmable pattern, valid qualifier,
// overlap/non-overlap match modes and a saturating match counter.
module detect_sequence_programmable #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         new_bit,
    input  logic                         bit_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         count_clr,
    output logic                         detected,
    output logic                         primed,
    output logic [CNT_W-1:0]             match_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Active configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    // Stream state
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic               primed_q, primed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic [LEN_W-1:0]   len_clamped;
    logic               enough_bits;
    logic               bits_equal;
    logic               sample;
    logic               match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    always_comb begin
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_L) begin
            len_clamped = MAX_LEN_L;
        end else begin
            len_clamped = cfg_len;
        end
    end

    assign sample      = bit_valid & ~cfg_load;
    assign hist_shift  = {hist_q[MAX_LEN-2:0], new_bit};
    assign fill_inc    = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_sat    = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
    // A match needs len valid bits since the last clear, counting the one being sampled.
    assign enough_bits = (fill_inc >= {1'b0, len_q});
    assign bits_equal  = (((hist_shift ^ pat_q) & mask) == '0);
    assign match       = sample & enough_bits & bits_equal;

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        primed_d = primed_q;
        det_d    = 1'b0;

        if (cfg_load) begin
            pat_d    = cfg_pattern;
            len_d    = len_clamped;
            ovl_d    = cfg_overlap;
            hist_d   = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (sample) begin
            hist_d = hist_shift;
            det_d  = match;
            // Non-overlap mode forces len fresh bits before the next match.
            if (match && !ovl_q) begin
                fill_d = '0;
            end else begin
                fill_d = fill_sat;
            end
            primed_d = (fill_d >= len_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= '0;
            len_q    <= MAX_LEN_L;
            ovl_q    <= 1'b1;
            hist_q   <= '0;
            fill_q   <= '0;
            det_q    <= 1'b0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            det_q    <= det_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign detected    = det_q;
    assign primed      = primed_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_detect_sequence_programmable.sv
// Directed self-checking bench for detect_sequence_programmable (MAX_LEN=16, CNT_W=2).
module tb_detect_sequence_programmable;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst_n;
    logic               new_bit;
    logic               bit_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               detected;
    logic               primed;
    logic [CNT_W-1:0]   match_count;

    int n_checks = 0;
    int n_pass   = 0;

    detect_sequence_programmable #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_bit    (new_bit),
        .bit_valid  (bit_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .count_clr  (count_clr),
        .detected   (detected),
        .primed     (primed),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic clr);
        @(negedge clk);
        new_bit   = b;
        bit_valid = 1'b1;
        cfg_load  = 1'b0;
        count_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        bit_valid = 1'b0;
        cfg_load  = 1'b0;
        count_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic bv, input logic nb);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        bit_valid   = bv;
        new_bit     = nb;
        count_clr   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [23:0] stream;
    logic [3:0]  gap_bits;

    initial begin
        rst_n       = 1'b0;
        new_bit     = 1'b0;
        bit_valid   = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;
        stream      = 24'b0011_0101_1001_1001_1010_1000;
        gap_bits    = 4'b1010;
        repeat (2) @(posedge clk);
        #1;
        check("rst_detected", {31'b0, detected}, 0);
        check("rst_primed", {31'b0, primed}, 0);
        check("rst_count", {30'b0, match_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Base stream, overlapping
        load(16'b110011, 6, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 24; i++) begin
            send(stream[23-i], 1'b0);
            check($sformatf("ovl_det_%0d", i), {31'b0, detected}, (i == 12 || i == 16) ? 1 : 0);
        end
        check("ovl_count", {30'b0, match_count}, 2);

        // Same stream, non-overlapping
        load(16'b110011, 6, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 24; i++) begin
            send(stream[23-i], 1'b0);
            check($sformatf("novl_det_%0d", i), {31'b0, detected}, (i == 12) ? 1 : 0);
        end
        check("novl_count", {30'b0, match_count}, 1);

        // All-zero pattern must not match on cleared history
        load(16'h0000, 4, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0);
            check($sformatf("prime_det_%0d", i), {31'b0, detected}, 0);
            check($sformatf("prime_primed_%0d", i), {31'b0, primed}, 0);
        end
        send(1'b0, 1'b0);
        check("prime_det_3", {31'b0, detected}, 1);
        check("prime_primed_3", {31'b0, primed}, 1);

        // Valid gaps between bits
        load(16'b1010, 4, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int k = 0; k < 4; k++) begin
            send(gap_bits[3-k], 1'b0);
            check($sformatf("gap_det_bit%0d", k), {31'b0, detected}, (k == 3) ? 1 : 0);
            if (k < 3) begin
                for (int j = 0; j < 3; j++) begin
                    idle(1'b0);
                    check($sformatf("gap_det_idle%0d_%0d", k, j), {31'b0, detected}, 0);
                end
            end
        end
        idle(1'b0);
        check("gap_det_after", {31'b0, detected}, 0);
        check("gap_count", {30'b0, match_count}, 1);

        // Counter saturation and clear-vs-match priority
        load(16'h0001, 1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 1'b0);
            check($sformatf("sat_det_%0d", k), {31'b0, detected}, 1);
            check($sformatf("sat_count_%0d", k), {30'b0, match_count}, (k < 3) ? k + 1 : 3);
        end
        send(1'b1, 1'b1);
        check("sat_clr_det", {31'b0, detected}, 1);
        check("sat_clr_count", {30'b0, match_count}, 0);

        // Oversized length clamps to MAX_LEN
        load(16'hFFFF, 20, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 1'b0);
            check($sformatf("clamp_det_%0d", i), {31'b0, detected}, (i == 15) ? 1 : 0);
        end
        check("clamp_primed", {31'b0, primed}, 1);

        // Reset mid-stream, then defaults, then reconfig
        load(16'b110011, 6, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        check("pre_rst_det", {31'b0, detected}, 1);
        check("pre_rst_primed", {31'b0, primed}, 1);
        check("pre_rst_count", {30'b0, match_count}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_det", {31'b0, detected}, 0);
        check("async_rst_primed", {31'b0, primed}, 0);
        check("async_rst_count", {30'b0, match_count}, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        // Reset config: pattern 0, length MAX_LEN, overlap on
        for (int i = 0; i < 17; i++) begin
            send(1'b0, 1'b0);
            check($sformatf("dflt_det_%0d", i), {31'b0, detected}, (i >= 15) ? 1 : 0);
        end
        check("dflt_count", {30'b0, match_count}, 2);
        load(16'h0001, 0, 1'b1, 1'b0, 1'b0);
        check("len0_load_det", {31'b0, detected}, 0);
        check("len0_load_primed", {31'b0, primed}, 0);
        send(1'b1, 1'b0);
        check("len0_det", {31'b0, detected}, 1);
        check("len0_primed", {31'b0, primed}, 1);
        send(1'b0, 1'b0);
        check("len0_det_zero", {31'b0, detected}, 0);
        load(16'h0001, 1, 1'b1, 1'b1, 1'b1);
        check("ld_bv_det", {31'b0, detected}, 0);
        check("ld_bv_primed", {31'b0, primed}, 0);
        check("ld_bv_count", {30'b0, match_count}, 3);
        idle(1'b0);
        check("ld_bv_idle_det", {31'b0, detected}, 0);
        check("ld_bv_idle_primed", {31'b0, primed}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
